lsu_bus_if: RTL and testbench
=============================

Name: lsu_bus_if

Overview:
- Load/store unit directly downstream of the instruction decoder.
- Consumes the decoder's memory request, write-enable and 3-bit size/funct3 code, plus the ALU-computed address and rs2 data.
- Runs a req/gnt/rvalid transaction on the data-memory bus, formats store lanes and load results (sign/zero extension), and stalls the core until the access completes.

Parameters:
- TIMEOUT, 255, bus-wait cycles allowed in REQ or WAIT_RV before abort with lsu_err_o; 0 disables the timeout.

Ports:
- clk_i  in  1  core clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- lsu_req_i  in  1  memory instruction in execute (decoder mem_req).
- lsu_we_i  in  1  1=store, 0=load (decoder mem_we).
- lsu_size_i  in  3  0=B, 1=H, 2=W, 4=BU, 5=HU (decoder mem_size).
- lsu_addr_i  in  32  byte address from ALU.
- lsu_wdata_i  in  32  rs2 store data.
- lsu_data_o  out  32  formatted load result, valid while lsu_stall_o=0 after a load.
- lsu_stall_o  out  1  core stall request.
- lsu_err_o  out  1  one-cycle pulse: misaligned, illegal size, or bus timeout.
- data_req_o  out  1  bus request.
- data_we_o  out  1  bus write.
- data_be_o  out  4  byte enables.
- data_addr_o  out  32  word address {lsu_addr_i[31:2],2'b00}.
- data_wdata_o  out  32  lane-replicated store data.
- data_gnt_i  in  1  request accepted.
- data_rvalid_i  in  1  read data valid.
- data_rdata_i  in  32  read word.

Behaviour:
- Reset: async on rstn_i=0. State IDLE. Timeout counter 0. lsu_data_o, data_addr_o, data_wdata_o are 0. data_be_o is 0. data_req_o, data_we_o, lsu_err_o are 0.
- States: IDLE, REQ, WAIT_RV, DONE. lsu_stall_o = lsu_req_i & (state!=DONE), combinational.
- IDLE, lsu_req_i=1:
  - Legality check: size in {0,1,2,4,5}; no store with size 4/5; H needs addr[0]=0; W needs addr[1:0]=0.
  - Illegal: go to DONE with no bus activity; lsu_err_o=1 during DONE.
  - Legal: register addr/we/be/wdata and go to REQ.
- Byte enables: B=4'b0001<<addr[1:0]; H=4'b0011<<addr[1:0]; W=4'b1111.
- Store data: SB={4{wdata[7:0]}}, SH={2{wdata[15:0]}}, SW=wdata.
- REQ:
  - data_req_o=1, bus outputs held stable.
  - On data_gnt_i: store goes to DONE; load goes to WAIT_RV.
  - data_req_o drops the cycle after gnt.
- WAIT_RV:
  - On data_rvalid_i: register formatted data into lsu_data_o, go to DONE.
  - rvalid in the same cycle as gnt is not accepted; rvalid arrives at least one cycle after gnt.
- Load formatting:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - Signed sizes sign-extend, unsigned sizes zero-extend.
  - LW passes the word through.
- DONE: lsu_stall_o=0 for exactly one cycle, then IDLE. lsu_data_o holds until the next load completes.
- Timeout:
  - Counter clears on entering REQ/WAIT_RV and increments each waiting cycle.
  - When it reaches TIMEOUT (TIMEOUT≠0): data_req_o drops, go to DONE with lsu_err_o=1, lsu_data_o unchanged.
- Late handshakes: gnt/rvalid arriving in IDLE or DONE are ignored.
- lsu_req_i deasserted mid-transaction (flush): the transaction still completes on the bus; the FSM returns to IDLE through DONE.
- Reset mid-transaction: immediate IDLE, data_req_o=0; later rvalid is ignored.
- Latency (gnt same cycle as req): store 2 stall cycles; load 3 stall cycles with rvalid at the earliest cycle; back-to-back accesses separated by the IDLE cycle.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt at first REQ cycle → data_addr_o=0x100, be=4'b1111, we=1. Stall high 2 cycles, then 1 cycle low. No error.
- SB addr=0x103, wdata=0x000000A5 → be=4'b1000, data_wdata_o=0xA5A5A5A5.
- LB addr=0x202, rdata=0x12F03456 → lsu_data_o=0xFFFFFFF0. LBU same access → 0x000000F0. LH addr=0x202 → 0x000012F0.
- LW addr=0x301 → no data_req_o; lsu_err_o pulses once in DONE; stall released after 1 cycle.
- TIMEOUT=4, load with gnt but rvalid never asserted → lsu_err_o pulse after 4 wait cycles; lsu_data_o unchanged; FSM back in IDLE.
- rstn_i low while in WAIT_RV → all outputs zero at once; an rvalid after release produces no lsu_data_o update.

Source files
------------

// File: rtl/lsu_bus_if.sv
// Load/store unit bus interface: runs a req/gnt/rvalid access per memory instruction,
// formats store lanes and load results, and stalls the core until the access retires.
module lsu_bus_if #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitRv, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d;
    logic        err_q, err_d;

    logic        legal;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] load_fmt;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        timeout_hit;

    // Request legality and lane formatting of the incoming instruction.
    always_comb begin
        legal = 1'b1;
        unique case (lsu_size_i)
            3'd0:       legal = 1'b1;
            3'd1:       legal = ~lsu_addr_i[0];
            3'd2:       legal = (lsu_addr_i[1:0] == 2'b00);
            3'd4:       legal = ~lsu_we_i;
            3'd5:       legal = ~lsu_we_i & ~lsu_addr_i[0];
            default:    legal = 1'b0;
        endcase

        be_new    = 4'b1111;
        wdata_new = lsu_wdata_i;
        unique case (lsu_size_i[1:0])
            2'd0: begin
                be_new    = 4'b0001 << lsu_addr_i[1:0];
                wdata_new = {4{lsu_wdata_i[7:0]}};
            end
            2'd1: begin
                be_new    = 4'b0011 << lsu_addr_i[1:0];
                wdata_new = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = lsu_wdata_i;
            end
        endcase
    end

    // Load result extraction from the captured byte offset and size.
    always_comb begin
        ld_byte = 8'h00;
        unique case (off_q)
            2'd0:    ld_byte = data_rdata_i[7:0];
            2'd1:    ld_byte = data_rdata_i[15:8];
            2'd2:    ld_byte = data_rdata_i[23:16];
            default: ld_byte = data_rdata_i[31:24];
        endcase
        ld_half = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];

        unique case (size_q)
            3'd0:    load_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    load_fmt = {24'h000000, ld_byte};
            3'd1:    load_fmt = {{16{ld_half[15]}}, ld_half};
            3'd5:    load_fmt = {16'h0000, ld_half};
            default: load_fmt = data_rdata_i;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && ((cnt_q + 32'd1) == 32'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        be_d    = be_q;
        size_d  = size_q;
        off_d   = off_q;
        we_d    = we_q;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (lsu_req_i) begin
                    if (legal) begin
                        addr_d  = {lsu_addr_i[31:2], 2'b00};
                        wdata_d = wdata_new;
                        be_d    = be_new;
                        we_d    = lsu_we_i;
                        size_d  = lsu_size_i;
                        off_d   = lsu_addr_i[1:0];
                        cnt_d   = 32'd0;
                        state_d = StReq;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StReq: begin
                if (data_gnt_i) begin
                    cnt_d   = 32'd0;
                    state_d = we_q ? StDone : StWaitRv;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StWaitRv: begin
                if (data_rvalid_i) begin
                    data_d  = load_fmt;
                    state_d = StDone;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            data_q  <= 32'd0;
            cnt_q   <= 32'd0;
            be_q    <= 4'd0;
            size_q  <= 3'd0;
            off_q   <= 2'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            be_q    <= be_d;
            size_q  <= size_d;
            off_q   <= off_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    assign lsu_stall_o  = lsu_req_i & (state_q != StDone);
    assign lsu_err_o    = err_q & (state_q == StDone);
    assign lsu_data_o   = data_q;
    assign data_req_o   = (state_q == StReq);
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = addr_q;
    assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Directed bench for lsu_bus_if: stores, loads with extension, misalignment,
// rvalid timeout and reset during an outstanding load.
module tb_lsu_bus_if;

    logic        clk;
    logic        rstn;
    logic        lsu_req;
    logic        lsu_we;
    logic [2:0]  lsu_size;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_data;
    logic        lsu_stall;
    logic        lsu_err;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    int n_chk;
    int n_fail;

    lsu_bus_if #(.TIMEOUT(4)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .lsu_req_i     (lsu_req),
        .lsu_we_i      (lsu_we),
        .lsu_size_i    (lsu_size),
        .lsu_addr_i    (lsu_addr),
        .lsu_wdata_i   (lsu_wdata),
        .lsu_data_o    (lsu_data),
        .lsu_stall_o   (lsu_stall),
        .lsu_err_o     (lsu_err),
        .data_req_o    (data_req),
        .data_we_o     (data_we),
        .data_be_o     (data_be),
        .data_addr_o   (data_addr),
        .data_wdata_o  (data_wdata),
        .data_gnt_i    (data_gnt),
        .data_rvalid_i (data_rvalid),
        .data_rdata_i  (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a negedge; outputs are sampled 1 time unit later.
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_store(input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input string tag);
        nxt();
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = size; lsu_addr = addr; lsu_wdata = wdata;
        data_gnt = 1'b1;
        #1;
        chk({tag, "_idle_stall"}, {31'd0, lsu_stall}, 32'd1);
        chk({tag, "_idle_req"}, {31'd0, data_req}, 32'd0);
        nxt(); #1;
        chk({tag, "_req"}, {31'd0, data_req}, 32'd1);
        chk({tag, "_we"}, {31'd0, data_we}, 32'd1);
        chk({tag, "_addr"}, data_addr, {addr[31:2], 2'b00});
        chk({tag, "_be"}, {28'd0, data_be}, {28'd0, exp_be});
        chk({tag, "_wdata"}, data_wdata, exp_wd);
        chk({tag, "_req_stall"}, {31'd0, lsu_stall}, 32'd1);
        nxt(); #1;
        chk({tag, "_done_stall"}, {31'd0, lsu_stall}, 32'd0);
        chk({tag, "_done_req"}, {31'd0, data_req}, 32'd0);
        chk({tag, "_done_err"}, {31'd0, lsu_err}, 32'd0);
        lsu_req = 1'b0; data_gnt = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_data,
                           input string tag);
        nxt();
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = size; lsu_addr = addr;
        data_gnt = 1'b1;
        nxt(); #1;
        chk({tag, "_req"}, {31'd0, data_req}, 32'd1);
        chk({tag, "_we"}, {31'd0, data_we}, 32'd0);
        nxt();
        data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = rdata;
        #1;
        chk({tag, "_wait_stall"}, {31'd0, lsu_stall}, 32'd1);
        chk({tag, "_wait_req"}, {31'd0, data_req}, 32'd0);
        nxt(); #1;
        chk({tag, "_done_stall"}, {31'd0, lsu_stall}, 32'd0);
        chk({tag, "_data"}, lsu_data, exp_data);
        lsu_req = 1'b0; data_rvalid = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rstn = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = 3'd0;
        lsu_addr = 32'd0; lsu_wdata = 32'd0;
        data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = 32'd0;
        #12;
        chk("rst_data", lsu_data, 32'd0);
        chk("rst_req", {31'd0, data_req}, 32'd0);
        chk("rst_be", {28'd0, data_be}, 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_err", {31'd0, lsu_err}, 32'd0);
        nxt();
        rstn = 1'b1;

        do_store(3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, "sw");
        do_store(3'd0, 32'h0000_0103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, "sb");
        do_store(3'd1, 32'h0000_0106, 32'h0000_1234, 4'b1100, 32'h1234_1234, "sh");

        do_load(3'd0, 32'h0000_0202, 32'h12F0_3456, 32'hFFFF_FFF0, "lb");
        do_load(3'd4, 32'h0000_0202, 32'h12F0_3456, 32'h0000_00F0, "lbu");
        do_load(3'd1, 32'h0000_0202, 32'h12F0_3456, 32'h0000_12F0, "lh");
        do_load(3'd5, 32'h0000_0200, 32'h12F0_8456, 32'h0000_8456, "lhu");
        do_load(3'd2, 32'h0000_0204, 32'hCAFE_F00D, 32'hCAFE_F00D, "lw");

        // Misaligned word load: no bus activity, single error pulse.
        nxt();
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h0000_0301;
        #1;
        chk("mis_idle_stall", {31'd0, lsu_stall}, 32'd1);
        nxt(); #1;
        chk("mis_req", {31'd0, data_req}, 32'd0);
        chk("mis_err", {31'd0, lsu_err}, 32'd1);
        chk("mis_stall", {31'd0, lsu_stall}, 32'd0);
        chk("mis_data", lsu_data, 32'hCAFE_F00D);
        lsu_req = 1'b0;
        nxt(); #1;
        chk("mis_err_clr", {31'd0, lsu_err}, 32'd0);

        // Unsigned-size store is illegal.
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 3'd4; lsu_addr = 32'h0000_0400;
        nxt(); #1;
        chk("sbu_err", {31'd0, lsu_err}, 32'd1);
        chk("sbu_req", {31'd0, data_req}, 32'd0);
        lsu_req = 1'b0;

        // Timeout: granted load whose rvalid never arrives.
        nxt();
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h0000_0500;
        data_gnt = 1'b1;
        nxt(); #1;
        chk("to_req", {31'd0, data_req}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            nxt();
            data_gnt = 1'b0;
            #1;
            chk($sformatf("to_wait%0d_stall", i), {31'd0, lsu_stall}, 32'd1);
            chk($sformatf("to_wait%0d_err", i), {31'd0, lsu_err}, 32'd0);
        end
        nxt(); #1;
        chk("to_err", {31'd0, lsu_err}, 32'd1);
        chk("to_stall", {31'd0, lsu_stall}, 32'd0);
        chk("to_data", lsu_data, 32'hCAFE_F00D);
        lsu_req = 1'b0;
        nxt(); #1;
        chk("to_err_clr", {31'd0, lsu_err}, 32'd0);

        // Reset while waiting for rvalid; a later rvalid must be ignored.
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h0000_0600;
        data_gnt = 1'b1;
        nxt();
        nxt();
        data_gnt = 1'b0;
        #1;
        chk("rw_wait_stall", {31'd0, lsu_stall}, 32'd1);
        rstn = 1'b0; lsu_req = 1'b0;
        #1;
        chk("rw_req", {31'd0, data_req}, 32'd0);
        chk("rw_addr", data_addr, 32'd0);
        chk("rw_data", lsu_data, 32'd0);
        nxt();
        rstn = 1'b1; data_rvalid = 1'b1; data_rdata = 32'h5555_AAAA;
        nxt(); #1;
        chk("rw_late_data", lsu_data, 32'd0);
        chk("rw_late_stall", {31'd0, lsu_stall}, 32'd0);
        data_rvalid = 1'b0;
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
